// File: rtl/vga_dls_comparator_if.sv
// rtl/vga_dls_comparator_if.sv - video sync/pixel bundle from the main and shadow VGA cores
interface vga_dls_comparator_if;
   logic       main_hsync;
   logic       main_vsync;
   logic [7:0] main_rgb;
   logic       shadow_hsync;
   logic       shadow_vsync;
   logic [7:0] shadow_rgb;

   // master: the pair of VGA cores producing the streams
   modport master (
      output main_hsync, main_vsync, main_rgb,
      output shadow_hsync, shadow_vsync, shadow_rgb
   );

   // slave: the lockstep comparator observing both streams
   modport slave (
      input main_hsync, main_vsync, main_rgb,
      input shadow_hsync, shadow_vsync, shadow_rgb
   );
endinterface

// File: rtl/vga_dls_comparator.sv
// rtl/vga_dls_comparator.sv - delayed-lockstep comparator for a main/shadow VGA core pair
module vga_dls_comparator #(
   parameter int DELAY = 2,
   parameter int LIMIT = 3
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   vga_dls_comparator_if.slave   vid,
   input  logic                  err_clear,
   output logic                  DLS_ERROR,
   output logic [7:0]            mismatch_cnt,
   output logic [1:0]            state
);

   typedef enum logic [1:0] {
      FILL    = 2'd0,
      CHECK   = 2'd1,
      SUSPECT = 2'd2,
      ERROR   = 2'd3
   } state_t;

   logic [9:0] main_word;
   logic [9:0] shadow_word;
   logic [9:0] dly_q [DELAY];
   logic       mism;

   state_t     state_q;
   logic [2:0] warm_q;
   logic [3:0] consec_q;
   logic       err_q;
   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign main_word   = {vid.main_hsync, vid.main_vsync, vid.main_rgb};
   assign shadow_word = {vid.shadow_hsync, vid.shadow_vsync, vid.shadow_rgb};

   // the oldest delay-line entry lines up in time with the current shadow word
   assign mism = (dly_q[DELAY-1] != shadow_word);

   // main-word delay line; keeps shifting through every state so it stays aligned after err_clear
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         for (int i = 0; i < DELAY; i++) dly_q[i] <= '0;
      end else begin
         dly_q[0] <= main_word;
         for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   // saturating mismatch counter next value; only live compares (CHECK/SUSPECT) count
   always_comb begin
      cnt_d = cnt_q;
      if ((state_q == CHECK || state_q == SUSPECT) && mism && cnt_q != 8'hFF)
         cnt_d = cnt_q + 8'd1;
   end

   // mismatch counter register, cleared only by reset
   always_ff @(posedge HCLK) begin
      if (HRESET) cnt_q <= 8'd0;
      else        cnt_q <= cnt_d;
   end

   // lockstep FSM: warm-up, checking, consecutive-mismatch tracking, sticky error
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= FILL;
         warm_q   <= 3'd0;
         consec_q <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            FILL: begin
               if (warm_q == 3'(DELAY - 1)) begin
                  state_q <= CHECK;
               end else begin
                  warm_q <= warm_q + 3'd1;
               end
            end
            CHECK: begin
               if (mism) begin
                  if (LIMIT == 1) begin
                     state_q  <= ERROR;
                     err_q    <= 1'b1;
                     consec_q <= 4'd1;
                  end else begin
                     state_q  <= SUSPECT;
                     consec_q <= 4'd1;
                  end
               end
            end
            SUSPECT: begin
               if (mism) begin
                  consec_q <= consec_q + 4'd1;
                  if (consec_q + 4'd1 == 4'(LIMIT)) begin
                     state_q <= ERROR;
                     err_q   <= 1'b1;
                  end
               end else begin
                  state_q  <= CHECK;
                  consec_q <= 4'd0;
               end
            end
            ERROR: begin
               if (err_clear) begin
                  state_q  <= FILL;
                  warm_q   <= 3'd0;
                  consec_q <= 4'd0;
                  err_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= FILL;
               warm_q  <= 3'd0;
            end
         endcase
      end
   end

   assign DLS_ERROR    = err_q;
   assign mismatch_cnt = cnt_q;
   assign state        = state_q;

endmodule

// File: tb/tb_vga_dls_comparator.sv
// tb/tb_vga_dls_comparator.sv - directed self-checking bench for vga_dls_comparator
module tb_vga_dls_comparator;

   logic       HCLK = 1'b0;
   logic       HRESET;
   logic       err_clear;
   logic       DLS_ERROR;
   logic [7:0] mismatch_cnt;
   logic [1:0] state;

   int vecs = 0;
   int miscompares = 0;

   // main words of the previous two cycles (hist1 is what the shadow must show now)
   logic [9:0] hist0;
   logic [9:0] hist1;
   logic [9:0] w;

   vga_dls_comparator_if vif ();

   vga_dls_comparator #(.DELAY(2), .LIMIT(3)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .vid         (vif.slave),
      .err_clear   (err_clear),
      .DLS_ERROR   (DLS_ERROR),
      .mismatch_cnt(mismatch_cnt),
      .state       (state)
   );

   always #5 HCLK = ~HCLK;

   // one clock: drive main word and shadow (= main two cycles ago ^ smask), then sample at negedge
   task automatic step(input logic [9:0] mword, input logic [9:0] smask, input logic clr);
      logic [9:0] sw;
      sw = hist1 ^ smask;
      vif.main_hsync   = mword[9];
      vif.main_vsync   = mword[8];
      vif.main_rgb     = mword[7:0];
      vif.shadow_hsync = sw[9];
      vif.shadow_vsync = sw[8];
      vif.shadow_rgb   = sw[7:0];
      err_clear        = clr;
      @(posedge HCLK);
      if (HRESET) begin
         hist0 = '0;
         hist1 = '0;
      end else begin
         hist1 = hist0;
         hist0 = mword;
      end
      @(negedge HCLK);
      err_clear = 1'b0;
   endtask

   task automatic test_reset;
      HRESET = 1'b1;
      step(10'h000, 10'h000, 1'b0);
      step(10'h000, 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", DLS_ERROR); end
      vecs++;
      if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_cnt: got %0d expected 0", mismatch_cnt); end
   endtask

   task automatic test_match;
      HRESET = 1'b0;
      step(10'($urandom), 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL fill_cycle1: got %0d expected 0", state); end
      step(10'($urandom), 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL fill_to_check: got %0d expected 1", state); end
      for (int i = 0; i < 1000; i++) begin
         step(10'($urandom), 10'h000, 1'b0);
         vecs++;
         if (state !== 2'd1) begin miscompares++; $display("FAIL match_state cyc %0d: got %0d expected 1", i, state); end
      end
      vecs++;
      if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL match_cnt: got %0d expected 0", mismatch_cnt); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL match_err: got %b expected 0", DLS_ERROR); end
   endtask

   task automatic test_single_corrupt;
      w = {2'b10, 8'h5A};
      step(w, 10'h000, 1'b0);
      step(w, 10'h000, 1'b1);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL clear_outside_error: got %0d expected 1", state); end
      step(w, 10'h001, 1'b0);
      vecs++;
      if (state !== 2'd2) begin miscompares++; $display("FAIL single_suspect: got %0d expected 2", state); end
      vecs++;
      if (mismatch_cnt !== 8'd1) begin miscompares++; $display("FAIL single_cnt: got %0d expected 1", mismatch_cnt); end
      step(w, 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL single_back_check: got %0d expected 1", state); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL single_err: got %b expected 0", DLS_ERROR); end
      vecs++;
      if (mismatch_cnt !== 8'd1) begin miscompares++; $display("FAIL single_cnt_hold: got %0d expected 1", mismatch_cnt); end
   endtask

   task automatic test_limit;
      w = {2'b01, 8'hC3};
      HRESET = 1'b1;
      step(w, 10'h000, 1'b0);
      HRESET = 1'b0;
      for (int i = 0; i < 4; i++) step(w, 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL limit_pre_state: got %0d expected 1", state); end
      step(w, 10'h200, 1'b0);
      step(w, 10'h200, 1'b0);
      vecs++;
      if (state !== 2'd2) begin miscompares++; $display("FAIL limit_two_state: got %0d expected 2", state); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL limit_two_err: got %b expected 0", DLS_ERROR); end
      step(w, 10'h200, 1'b0);
      vecs++;
      if (state !== 2'd3) begin miscompares++; $display("FAIL limit_three_state: got %0d expected 3", state); end
      vecs++;
      if (DLS_ERROR !== 1'b1) begin miscompares++; $display("FAIL limit_three_err: got %b expected 1", DLS_ERROR); end
      vecs++;
      if (mismatch_cnt !== 8'd3) begin miscompares++; $display("FAIL limit_three_cnt: got %0d expected 3", mismatch_cnt); end
      step(w, 10'h200, 1'b0);
      vecs++;
      if (mismatch_cnt !== 8'd3) begin miscompares++; $display("FAIL error_no_count: got %0d expected 3", mismatch_cnt); end
      vecs++;
      if (state !== 2'd3) begin miscompares++; $display("FAIL error_sticky: got %0d expected 3", state); end
   endtask

   task automatic test_clear;
      step(w, 10'h000, 1'b1);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL clear_fill1: got %0d expected 0", state); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL clear_err: got %b expected 0", DLS_ERROR); end
      step(w, 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL clear_fill2: got %0d expected 0", state); end
      step(w, 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL clear_check: got %0d expected 1", state); end
      for (int i = 0; i < 5; i++) step(10'($urandom), 10'h000, 1'b0);
      vecs++;
      if (state !== 2'd1) begin miscompares++; $display("FAIL clear_run_state: got %0d expected 1", state); end
      vecs++;
      if (mismatch_cnt !== 8'd3) begin miscompares++; $display("FAIL clear_cnt_kept: got %0d expected 3", mismatch_cnt); end
   endtask

   task automatic test_saturate;
      int exp_cnt;
      exp_cnt = 3;
      for (int i = 0; i < 600; i++) begin
         if (i % 2 == 0) begin
            step(10'($urandom), 10'h0FF, 1'b0);
            if (exp_cnt < 255) exp_cnt++;
            vecs++;
            if (state !== 2'd2) begin miscompares++; $display("FAIL sat_suspect cyc %0d: got %0d expected 2", i, state); end
         end else begin
            step(10'($urandom), 10'h000, 1'b0);
            vecs++;
            if (state !== 2'd1) begin miscompares++; $display("FAIL sat_check cyc %0d: got %0d expected 1", i, state); end
         end
         vecs++;
         if (mismatch_cnt !== 8'(exp_cnt)) begin miscompares++; $display("FAIL sat_cnt cyc %0d: got %0d expected %0d", i, mismatch_cnt, exp_cnt); end
      end
      vecs++;
      if (mismatch_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_final: got %0d expected 255", mismatch_cnt); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL sat_err: got %b expected 0", DLS_ERROR); end
      HRESET = 1'b1;
      step(10'h000, 10'h000, 1'b0);
      vecs++;
      if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL sat_reset_cnt: got %0d expected 0", mismatch_cnt); end
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL sat_reset_state: got %0d expected 0", state); end
      HRESET = 1'b0;
   endtask

   task automatic test_reset_mid;
      w = {2'b11, 8'h0F};
      for (int i = 0; i < 4; i++) step(w, 10'h000, 1'b0);
      for (int i = 0; i < 3; i++) step(w, 10'h100, 1'b0);
      vecs++;
      if (state !== 2'd3) begin miscompares++; $display("FAIL mid_error_state: got %0d expected 3", state); end
      HRESET = 1'b1;
      step(w, 10'h000, 1'b1);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
      vecs++;
      if (DLS_ERROR !== 1'b0) begin miscompares++; $display("FAIL mid_reset_err: got %b expected 0", DLS_ERROR); end
      vecs++;
      if (mismatch_cnt !== 8'd0) begin miscompares++; $display("FAIL mid_reset_cnt: got %0d expected 0", mismatch_cnt); end
      HRESET = 1'b0;
      step(w, 10'h3FF, 1'b0);
      vecs++;
      if (state !== 2'd0) begin miscompares++; $display("FAIL mid_fill_ignore: got %0d expected 0", state); end
      step(w, 10'h3FF, 1'b0);
      vecs++;
      if (state !== 2'd1 || mismatch_cnt !== 8'd0) begin
         miscompares++; $display("FAIL mid_fill_done: got state %0d cnt %0d expected 1 0", state, mismatch_cnt);
      end
      step(w, 10'h001, 1'b0);
      vecs++;
      if (state !== 2'd2 || mismatch_cnt !== 8'd1) begin
         miscompares++; $display("FAIL mid_first_compare: got state %0d cnt %0d expected 2 1", state, mismatch_cnt);
      end
   endtask

   initial begin
      HRESET           = 1'b1;
      err_clear        = 1'b0;
      hist0            = '0;
      hist1            = '0;
      w                = '0;
      vif.main_hsync   = 1'b0;
      vif.main_vsync   = 1'b0;
      vif.main_rgb     = 8'h00;
      vif.shadow_hsync = 1'b0;
      vif.shadow_vsync = 1'b0;
      vif.shadow_rgb   = 8'h00;
      @(negedge HCLK);
      test_reset();
      test_match();
      test_single_corrupt();
      test_limit();
      test_clear();
      test_saturate();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
